pwm_multi: RTL and testbench
============================

Name: pwm_multi

Overview:
- Parametrised multi-channel successor to the single-channel board-level PWM.
- Generates CHANNELS independent PWM outputs from one shared period counter.
- Supports a selectable edge-aligned or center-aligned mode.
- Duty registers are double-buffered and glitch-free: a new duty value only takes effect at a period boundary.
- Sits between the board top level (switch/key decode, HEX display) and GPIO pins.

Parameters:
- CLK_FREQ, 50_000_000: input clock frequency in Hz.
- PWM_FREQ, 1000: edge-mode PWM frequency in Hz. Center mode runs at about half this.
- CHANNELS, 4: number of PWM outputs (1..16).
- RES, 8: duty resolution in bits. Counter MAX = 2^RES-1.

Ports:
- MAX10_CLK1_50 input 1: system clock. The block has exactly one clock.
- RST input 1: reset, synchronous, active-high. The top level drives it from inverted KEY[0].
- ENABLE input 1: run enable. When low, the counter is held and outputs are idle.
- CENTER input 1: 0 = edge-aligned, 1 = center-aligned. Sampled at a period boundary.
- POLARITY input CHANNELS: per-channel output inversion. 1 = active-low.
- WR_EN input 1: duty write strobe. Single cycle, no back-pressure.
- WR_ADDR input $clog2(CHANNELS): target channel.
- WR_DATA input RES+1: duty value, 0..2^RES.
- PWM_OUT output CHANNELS: PWM outputs, registered.
- PERIOD_START output 1: one-cycle pulse on each period boundary.

Behaviour:
- Prescaler
  - DIV = max(1, CLK_FREQ/(PWM_FREQ*2^RES)).
  - The prescaler counts 0..DIV-1; TICK is asserted on the cycle it equals DIV-1, then it wraps.
- Edge mode
  - CNT goes 0,1,..,MAX then wraps to 0, advancing on TICK.
  - Period = 2^RES ticks.
  - Raw output = (CNT < duty_active). Duty 0 gives 0%; duty 2^RES gives 100%.
- Center mode
  - CNT goes 0,1,..,MAX,MAX-1,..,1, then back to 0; a DIR bit tracks up/down.
  - Period = 2*MAX ticks.
  - Raw output = (CNT < duty_active), so high time = min(2*duty-1, 2*MAX) ticks for duty ≥ 1, and 0 for duty = 0.
- Period boundary: the TICK on which CNT becomes 0 (or the first TICK after ENABLE rises).
  - At the boundary, every duty_active[i] is loaded from its shadow[i].
  - The mode latch is loaded from CENTER.
  - PERIOD_START pulses for one cycle, aligned with CNT==0.
- Writes
  - WR_EN loads shadow[WR_ADDR] <= min(WR_DATA, 2^RES). Values above 2^RES saturate.
  - WR_ADDR ≥ CHANNELS is ignored.
- Write on a boundary cycle: the bypass is taken, so the new value lands in duty_active at that same boundary.
- Output
  - PWM_OUT[i] = raw[i] XOR POLARITY[i], registered.
  - Latency is 1 cycle from the CNT update.
- ENABLE low
  - Prescaler, CNT and DIR are forced to 0 and the output raw value is 0 (PWM_OUT = POLARITY).
  - Writes to the shadow registers are still accepted.
- Mode change mid-period: ignored until the next boundary, so the current period completes in the old mode.
- Reset (takes effect on the next clock edge and overrides everything, including mid-period)
  - Prescaler, CNT, DIR, shadow and active duties are all cleared to 0; mode latch = edge.
  - PWM_OUT = 0 and PERIOD_START = 0.
  - POLARITY is not applied during reset.

Decomposition:
- Package pwm_pkg holds:
  - the mode encoding (MODE_EDGE = 0, MODE_CENTER = 1);
  - the DIV computation function;
  - a clamp-to-2^RES helper function.
- One natural sub-module, pwm_timebase, contains the prescaler, CNT/DIR and boundary/PERIOD_START generation.
- The top level holds the duty register file, compare logic and output stage, using a generate loop over CHANNELS.

Test Plan:
All scenarios use CLK_FREQ=1600, PWM_FREQ=100, RES=4, CHANNELS=4 (DIV=1, edge period 16 cycles).
- Reset, ENABLE=1, write ch0=4, ch1=0, ch2=16, ch3=20 -> after the next boundary, each 16-cycle period shows:
  - ch0 high for 4 cycles;
  - ch1 constantly low;
  - ch2 constantly high;
  - ch3 constantly high (value saturated to 16).
- Write ch0=8 mid-period -> the current period keeps 4 high cycles; the next period has 8. PERIOD_START pulses exactly every 16 cycles.
- CENTER=1 set mid-period, ch0=4 -> mode switches at the next boundary; period becomes 30 cycles, ch0 is high for 7 cycles, centered on CNT=0.
- POLARITY=4'b0001 with ENABLE=0 -> PWM_OUT=4'b0001 and CNT holds at 0. Raising ENABLE produces the first PERIOD_START 1 cycle later.
- Write coinciding with a boundary cycle (ch1=2) -> 2 high cycles in the period that starts at that boundary.
- RST asserted mid-period for 1 cycle -> the next cycle shows PWM_OUT=0, all duties 0, and the edge mode restored.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the multi-channel PWM.
//   - pwm_mode_e : counter mode encoding (edge / center aligned)
//   - calc_div   : prescaler divide ratio, never below 1
//   - clamp_duty : saturate a duty value to 2^res
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  function automatic int unsigned calc_div(int unsigned clk_freq, int unsigned pwm_freq,
                                           int unsigned res);
    int unsigned d;
    d = clk_freq / (pwm_freq * (32'd1 << res));
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int unsigned clamp_duty(int unsigned val, int unsigned res);
    int unsigned lim;
    lim = 32'd1 << res;
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: shared prescaler and period counter for pwm_multi.
// Ports:
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   enable_i       run enable; low holds prescaler/counter at zero
//   center_i       requested mode, latched at each period boundary
//   cnt_o          current counter value
//   run_o          high once the first boundary after enable has been seen
//   boundary_o     combinational: this cycle's edge starts a new period
//   period_start_o registered one-cycle pulse, coincident with cnt_o == 0
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned PWM_FREQ = 1000,
  parameter int unsigned RES      = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           enable_i,
  input  logic           center_i,
  output logic [RES-1:0] cnt_o,
  output logic           run_o,
  output logic           boundary_o,
  output logic           period_start_o
);

  localparam int unsigned Div  = calc_div(CLK_FREQ, PWM_FREQ, RES);
  localparam int unsigned PscW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [RES-1:0] CntMax = '1;

  logic [PscW-1:0] psc_q, psc_d;
  logic [RES-1:0]  cnt_q, cnt_d;
  logic            dir_q, dir_d;   // 0 = counting up, 1 = counting down
  pwm_mode_e       mode_q, mode_d;
  logic            run_q, run_d;
  logic            ps_q, ps_d;
  logic            tick;
  logic            boundary;

  always_comb begin
    psc_d    = psc_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    run_d    = run_q;
    ps_d     = 1'b0;
    tick     = 1'b0;
    boundary = 1'b0;
    if (!enable_i) begin
      psc_d = '0;
      cnt_d = '0;
      dir_d = 1'b0;
      run_d = 1'b0;
    end else begin
      tick  = (psc_q == PscW'(Div - 1));
      psc_d = tick ? '0 : psc_q + PscW'(1);
      if (tick) begin
        if (!run_q) begin
          cnt_d = '0;
        end else if (mode_q == MODE_EDGE) begin
          cnt_d = cnt_q + RES'(1);  // natural wrap MAX -> 0
        end else if (!dir_q) begin
          if (cnt_q == CntMax) begin
            cnt_d = cnt_q - RES'(1);
            dir_d = 1'b1;
          end else begin
            cnt_d = cnt_q + RES'(1);
          end
        end else begin
          cnt_d = cnt_q - RES'(1);
        end
        // Start of a period: first tick after enabling, or counter returning to zero.
        if (!run_q || (cnt_d == '0)) begin
          boundary = 1'b1;
          run_d    = 1'b1;
          dir_d    = 1'b0;
          mode_d   = pwm_mode_e'(center_i);
          ps_d     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psc_q  <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      mode_q <= MODE_EDGE;
      run_q  <= 1'b0;
      ps_q   <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      mode_q <= mode_d;
      run_q  <= run_d;
      ps_q   <= ps_d;
    end
  end

  assign cnt_o          = cnt_q;
  assign run_o          = run_q;
  assign boundary_o     = boundary;
  assign period_start_o = ps_q;

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: CHANNELS independent PWM outputs sharing one timebase.
// Duties are double-buffered (shadow -> active at each period boundary).
// Ports:
//   MAX10_CLK1_50 system clock
//   RST           synchronous active-high reset
//   ENABLE        run enable; low idles outputs at POLARITY
//   CENTER        0 = edge-aligned, 1 = center-aligned (taken at boundary)
//   POLARITY      per-channel inversion, 1 = active-low
//   WR_EN/ADDR/DATA  duty write port, data saturates at 2^RES
//   PWM_OUT       registered PWM outputs
//   PERIOD_START  one-cycle pulse per period
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned PWM_FREQ = 1000,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned RES      = 8,
  localparam int unsigned AW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                MAX10_CLK1_50,
  input  logic                RST,
  input  logic                ENABLE,
  input  logic                CENTER,
  input  logic [CHANNELS-1:0] POLARITY,
  input  logic                WR_EN,
  input  logic [AW-1:0]       WR_ADDR,
  input  logic [RES:0]        WR_DATA,
  output logic [CHANNELS-1:0] PWM_OUT,
  output logic                PERIOD_START
);

  localparam int unsigned DW = RES + 1;

  logic [RES-1:0]      cnt;
  logic                run;
  logic                boundary;
  logic [DW-1:0]       wr_duty;
  logic                wr_valid;
  logic [CHANNELS-1:0] raw;
  logic [CHANNELS-1:0] pwm_q, pwm_d;

  pwm_timebase #(
    .CLK_FREQ (CLK_FREQ),
    .PWM_FREQ (PWM_FREQ),
    .RES      (RES)
  ) u_timebase (
    .clk_i          (MAX10_CLK1_50),
    .rst_i          (RST),
    .enable_i       (ENABLE),
    .center_i       (CENTER),
    .cnt_o          (cnt),
    .run_o          (run),
    .boundary_o     (boundary),
    .period_start_o (PERIOD_START)
  );

  assign wr_duty  = DW'(clamp_duty(32'(WR_DATA), RES));
  assign wr_valid = WR_EN && (32'(WR_ADDR) < CHANNELS);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DW-1:0] shadow_q, shadow_d;
    logic [DW-1:0] active_q, active_d;
    logic          wr_hit;

    assign wr_hit = wr_valid && (WR_ADDR == AW'(g));

    always_comb begin
      shadow_d = wr_hit ? wr_duty : shadow_q;
      active_d = active_q;
      // Loading from shadow_d lets a write on the boundary cycle take effect immediately.
      if (boundary) begin
        active_d = shadow_d;
      end
    end

    always_ff @(posedge MAX10_CLK1_50) begin
      if (RST) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
      end
    end

    assign raw[g] = ENABLE && run && ({1'b0, cnt} < active_q);
  end

  assign pwm_d = raw ^ POLARITY;

  always_ff @(posedge MAX10_CLK1_50) begin
    if (RST) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign PWM_OUT = pwm_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed self-checking bench for pwm_multi
// (CLK_FREQ=1600, PWM_FREQ=100, RES=4, CHANNELS=4 -> DIV=1, edge period 16).
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       center;
  logic [3:0] polarity;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [4:0] wr_data;
  logic [3:0] pwm_out;
  logic       period_start;

  int         checks = 0;
  int         passes = 0;
  int         hi[4];
  logic [63:0] tr0;
  logic [63:0] ps_tr;
  logic [63:0] exp_tr;

  always #5 clk = ~clk;

  pwm_multi #(
    .CLK_FREQ (1600),
    .PWM_FREQ (100),
    .CHANNELS (4),
    .RES      (4)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .RST           (rst),
    .ENABLE        (enable),
    .CENTER        (center),
    .POLARITY      (polarity),
    .WR_EN         (wr_en),
    .WR_ADDR       (wr_addr),
    .WR_DATA       (wr_data),
    .PWM_OUT       (pwm_out),
    .PERIOD_START  (period_start)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance len cycles from just after a boundary, recording per-channel high counts,
  // the ch0 trace and the PERIOD_START trace (bit k-1 = value after cycle k).
  task automatic run_period(input int len, input int wr_step, input int wr_ch,
                            input int wr_val, input int ctr_step);
    for (int i = 0; i < 4; i++) hi[i] = 0;
    tr0   = '0;
    ps_tr = '0;
    for (int k = 1; k <= len; k++) begin
      if (k == wr_step) begin
        wr_en   = 1'b1;
        wr_addr = 2'(wr_ch);
        wr_data = 5'(wr_val);
      end else begin
        wr_en = 1'b0;
      end
      if (k == ctr_step) center = 1'b1;
      step();
      for (int i = 0; i < 4; i++) hi[i] = hi[i] + ((pwm_out[i] === 1'b1) ? 1 : 0);
      tr0[k-1]   = pwm_out[0];
      ps_tr[k-1] = period_start;
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; center = 1'b0; polarity = 4'hF;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    step();
    step();
    checks++;
    if (pwm_out !== 4'h0) $display("FAIL reset_pwm: got %b expected %b", pwm_out, 4'h0);
    else passes++;
    checks++;
    if (period_start !== 1'b0) $display("FAIL reset_ps: got %b expected 0", period_start);
    else passes++;
    rst = 1'b0;
    step();
    checks++;
    if (pwm_out !== 4'hF) $display("FAIL idle_polarity: got %b expected %b", pwm_out, 4'hF);
    else passes++;
    polarity = 4'h0;
    step();
  endtask

  task automatic test_edge_basic();
    int duty[4] = '{4, 0, 16, 20};
    int exp_hi[4] = '{4, 0, 16, 16};
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = 5'(duty[i]);
      step();
    end
    wr_en  = 1'b0;
    enable = 1'b1;
    step();
    checks++;
    if (period_start !== 1'b1) $display("FAIL first_ps: got %b expected 1", period_start);
    else passes++;
    run_period(16, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hi[i] !== exp_hi[i])
        $display("FAIL edge_hi_ch%0d: got %0d expected %0d", i, hi[i], exp_hi[i]);
      else passes++;
    end
    checks++;
    if (tr0 !== 64'hF) $display("FAIL edge_trace_ch0: got %h expected %h", tr0, 64'hF);
    else passes++;
    exp_tr = 64'd1 << 15;
    checks++;
    if (ps_tr !== exp_tr) $display("FAIL edge_ps: got %h expected %h", ps_tr, exp_tr);
    else passes++;
  endtask

  task automatic test_mid_period_write();
    run_period(16, 6, 0, 8, 0);
    checks++;
    if (hi[0] !== 4) $display("FAIL midwr_old_duty: got %0d expected 4", hi[0]);
    else passes++;
    exp_tr = 64'd1 << 15;
    checks++;
    if (ps_tr !== exp_tr) $display("FAIL midwr_ps: got %h expected %h", ps_tr, exp_tr);
    else passes++;
  endtask

  task automatic test_boundary_write();
    // Period also shows ch0 picking up 8; ch1=2 is written on the closing boundary.
    run_period(16, 16, 1, 2, 0);
    checks++;
    if (tr0 !== 64'hFF) $display("FAIL new_duty_trace: got %h expected %h", tr0, 64'hFF);
    else passes++;
    checks++;
    if (hi[1] !== 0) $display("FAIL bwr_before: got %0d expected 0", hi[1]);
    else passes++;
  endtask

  task automatic test_center();
    int exp_hi[4] = '{7, 3, 30, 30};
    // ch1 shows the boundary write; CENTER rises mid-period and ch0 shadow gets 4.
    run_period(16, 3, 0, 4, 5);
    checks++;
    if (hi[1] !== 2) $display("FAIL bwr_after: got %0d expected 2", hi[1]);
    else passes++;
    checks++;
    if (hi[0] !== 8) $display("FAIL ctr_old_period_ch0: got %0d expected 8", hi[0]);
    else passes++;
    exp_tr = 64'd1 << 15;
    checks++;
    if (ps_tr !== exp_tr) $display("FAIL ctr_old_period_ps: got %h expected %h", ps_tr, exp_tr);
    else passes++;
    run_period(30, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hi[i] !== exp_hi[i])
        $display("FAIL ctr_hi_ch%0d: got %0d expected %0d", i, hi[i], exp_hi[i]);
      else passes++;
    end
    checks++;
    if (tr0 !== 64'h3800_000F)
      $display("FAIL ctr_trace_ch0: got %h expected %h", tr0, 64'h3800_000F);
    else passes++;
    exp_tr = 64'd1 << 29;
    checks++;
    if (ps_tr !== exp_tr) $display("FAIL ctr_ps: got %h expected %h", ps_tr, exp_tr);
    else passes++;
  endtask

  task automatic test_enable_polarity();
    int exp_hi[4] = '{12, 2, 16, 16};
    enable = 1'b0; polarity = 4'b0001; center = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (pwm_out !== 4'b0001 || period_start !== 1'b0)
        $display("FAIL disabled_out: got %b/%b expected 0001/0", pwm_out, period_start);
      else passes++;
    end
    enable = 1'b1;
    step();
    checks++;
    if (period_start !== 1'b1) $display("FAIL enable_ps: got %b expected 1", period_start);
    else passes++;
    run_period(16, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hi[i] !== exp_hi[i])
        $display("FAIL pol_hi_ch%0d: got %0d expected %0d", i, hi[i], exp_hi[i]);
      else passes++;
    end
    checks++;
    if (tr0 !== 64'hFFF0) $display("FAIL pol_trace_ch0: got %h expected %h", tr0, 64'hFFF0);
    else passes++;
    exp_tr = 64'd1 << 15;
    checks++;
    if (ps_tr !== exp_tr) $display("FAIL pol_ps: got %h expected %h", ps_tr, exp_tr);
    else passes++;
  endtask

  task automatic test_reset_mid_period();
    int exp_hi[4] = '{16, 0, 0, 0};
    run_period(5, 0, 0, 0, 0);
    rst = 1'b1;
    step();
    checks++;
    if (pwm_out !== 4'h0) $display("FAIL midrst_pwm: got %b expected 0000", pwm_out);
    else passes++;
    checks++;
    if (period_start !== 1'b0) $display("FAIL midrst_ps: got %b expected 0", period_start);
    else passes++;
    rst = 1'b0;
    step();
    checks++;
    if (period_start !== 1'b1 || pwm_out !== 4'b0001)
      $display("FAIL postrst_first: got %b/%b expected 1/0001", period_start, pwm_out);
    else passes++;
    run_period(16, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hi[i] !== exp_hi[i])
        $display("FAIL postrst_hi_ch%0d: got %0d expected %0d", i, hi[i], exp_hi[i]);
      else passes++;
    end
    exp_tr = 64'd1 << 15;
    checks++;
    if (ps_tr !== exp_tr) $display("FAIL postrst_ps: got %h expected %h", ps_tr, exp_tr);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_mid_period_write();
    test_boundary_write();
    test_center();
    test_enable_polarity();
    test_reset_mid_period();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
